// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game datapath.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TIMING,
        ST_DONE,
        ST_FOUL,
        ST_TOUT
    } rt_state_t;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of wrapping.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] value_o,
    output logic        at_max_o
);

    logic [15:0] value_q, value_d;
    logic        carry;

    assign at_max_o = (value_q == BCD_MAX);
    assign value_o  = value_q;

    always_comb begin
        value_d = value_q;
        carry   = 1'b1;
        if (clr_i) begin
            value_d = BCD_ZERO;
        end else if (inc_i && !at_max_o) begin
            // Ripple the +1 through the digits; a 9 rolls to 0 and passes the carry on.
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (value_q[i*4 +: 4] == 4'd9) begin
                        value_d[i*4 +: 4] = 4'd0;
                    end else begin
                        value_d[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time measurement: arms the stimulus generator, times the response in ms (BCD),
// flags false starts and timeouts, and tracks the best valid time since reset.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// WAIT   | armed, waiting for randomtick
// TIMING | LED on, counting ms until a press
// DONE   | valid result in time_bcd
// FOUL   | pressed before the stimulus
// TOUT   | no press before 9999 ms
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn,
    input  logic        randomtick,
    output logic        stimulated,
    output logic        led,
    output logic [15:0] time_bcd,
    output logic [15:0] best_bcd,
    output logic        valid,
    output logic        false_start,
    output logic        timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    rt_state_t   state_q, state_d;
    logic        btn_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0] best_q, best_d;
    logic        press;
    logic        ms_wrap;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_at_max;
    logic [15:0] cnt_value;

    assign press   = btn & ~btn_q;
    assign ms_wrap = (state_q == ST_TIMING) && (presc_q == PRESC_LAST);
    assign cnt_clr = (state_d == ST_WAIT) && (state_q != ST_WAIT);
    // The press edge freezes the result, so a coincident ms wrap is not counted.
    assign cnt_inc = ms_wrap && (state_d == ST_TIMING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (press)           state_d = ST_FOUL;
                else if (randomtick) state_d = ST_TIMING;
            end
            ST_TIMING: begin
                if (cnt_at_max) state_d = ST_TOUT;
                else if (press) state_d = ST_DONE;
            end
            ST_DONE, ST_FOUL, ST_TOUT: begin
                if (start) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stimulated  = (state_q == ST_WAIT) || (state_q == ST_TIMING);
        led         = (state_q == ST_TIMING);
        valid       = (state_q == ST_DONE);
        false_start = (state_q == ST_FOUL);
        timeout     = (state_q == ST_TOUT);
    end

    always_comb begin
        presc_d = '0;
        if (state_q == ST_TIMING && !ms_wrap) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        best_d = best_q;
        if (state_q == ST_TIMING && state_d == ST_DONE && cnt_value < best_q) begin
            best_d = cnt_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q   <= 1'b0;
            presc_q <= '0;
            best_q  <= BCD_MAX;
        end else begin
            btn_q   <= btn;
            presc_q <= presc_d;
            best_q  <= best_d;
        end
    end

    bcd_counter4 u_ms_count (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .value_o  (cnt_value),
        .at_max_o (cnt_at_max)
    );

    assign time_bcd = cnt_value;
    assign best_bcd = best_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4: round table plus corner-case sequences.
module tb_reaction_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, start, btn, randomtick;
    logic        stimulated, led, valid, false_start, timeout;
    logic [15:0] time_bcd, best_bcd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reaction_timer #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn         (btn),
        .randomtick  (randomtick),
        .stimulated  (stimulated),
        .led         (led),
        .time_bcd    (time_bcd),
        .best_bcd    (best_bcd),
        .valid       (valid),
        .false_start (false_start),
        .timeout     (timeout)
    );

    typedef struct {
        int          wait_cyc;
        int          resp_cyc;
        bit          foul;
        logic [15:0] exp_time;
        logic [15:0] exp_best;
    } round_t;

    round_t rounds[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bcd_next(input logic [15:0] v);
        int n;
        n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
        if (n < 9999) n++;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    initial begin
        logic        led_any;
        logic [15:0] prev;
        bit          seen_0100, seen_1000;

        // Press in cycle k of TIMING gives floor(k/4) ms.
        rounds[0] = '{wait_cyc: 10, resp_cyc: 13, foul: 1'b0, exp_time: 16'h0003, exp_best: 16'h0003};
        rounds[1] = '{wait_cyc: 4,  resp_cyc: 21, foul: 1'b0, exp_time: 16'h0005, exp_best: 16'h0003};
        rounds[2] = '{wait_cyc: 2,  resp_cyc: 4,  foul: 1'b0, exp_time: 16'h0001, exp_best: 16'h0001};
        rounds[3] = '{wait_cyc: 3,  resp_cyc: 0,  foul: 1'b1, exp_time: 16'h0000, exp_best: 16'h0001};
        rounds[4] = '{wait_cyc: 1,  resp_cyc: 2,  foul: 1'b0, exp_time: 16'h0000, exp_best: 16'h0000};

        rst = 1'b1; start = 1'b0; btn = 1'b0; randomtick = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_stim",  16'(stimulated),  16'd0);
        chk("rst_led",   16'(led),         16'd0);
        chk("rst_valid", 16'(valid),       16'd0);
        chk("rst_foul",  16'(false_start), 16'd0);
        chk("rst_tout",  16'(timeout),     16'd0);
        chk("rst_time",  time_bcd,         16'h0000);
        chk("rst_best",  best_bcd,         16'h9999);

        foreach (rounds[r]) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("round_stim_on", 16'(stimulated), 16'd1);
            if (rounds[r].foul) begin
                led_any = 1'b0;
                repeat (rounds[r].wait_cyc) begin
                    tick();
                    led_any |= led;
                end
                btn = 1'b1;
                tick();
                led_any |= led;
                chk("foul_flag",     16'(false_start), 16'd1);
                chk("foul_stim_off", 16'(stimulated),  16'd0);
                chk("foul_led_seen", 16'(led_any),     16'd0);
                chk("foul_valid",    16'(valid),       16'd0);
            end else begin
                repeat (rounds[r].wait_cyc) tick();
                randomtick = 1'b1;
                tick();
                chk("round_led_on", 16'(led), 16'd1);
                repeat (rounds[r].resp_cyc) tick();
                btn = 1'b1;
                tick();
                chk("round_valid",   16'(valid), 16'd1);
                chk("round_led_off", 16'(led),   16'd0);
            end
            chk("round_time", time_bcd, rounds[r].exp_time);
            chk("round_best", best_bcd, rounds[r].exp_best);
            btn = 1'b0;
            randomtick = 1'b0;
            tick();
        end

        // press and randomtick in the same WAIT cycle: foul wins
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        randomtick = 1'b1;
        btn = 1'b1;
        tick();
        chk("same_cycle_foul", 16'(false_start), 16'd1);
        chk("same_cycle_led",  16'(led),         16'd0);
        randomtick = 1'b0;
        tick(); tick();

        // btn held high from before the round: only a fresh rising edge counts
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("held_wait", 16'(stimulated), 16'd1);
        repeat (3) tick();
        randomtick = 1'b1;
        tick();
        chk("held_timing", 16'(led), 16'd1);
        repeat (6) tick();
        chk("held_no_valid", 16'(valid), 16'd0);
        chk("held_still_on", 16'(led),   16'd1);
        btn = 1'b0;
        tick(); tick();
        btn = 1'b1;
        tick();
        chk("held_valid", 16'(valid), 16'd1);
        chk("held_time",  time_bcd,   16'h0002);
        chk("held_best",  best_bcd,   16'h0000);
        btn = 1'b0;
        randomtick = 1'b0;
        tick();

        // no press: run to saturation
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tout_cleared", time_bcd, 16'h0000);
        randomtick = 1'b1;
        tick();
        chk("tout_led", 16'(led), 16'd1);
        prev = time_bcd;
        seen_0100 = 1'b0;
        seen_1000 = 1'b0;
        for (int i = 0; i < 45000 && !timeout; i++) begin
            tick();
            if (time_bcd !== prev) begin
                chk("bcd_step", time_bcd, bcd_next(prev));
                if (prev == 16'h0099 && time_bcd == 16'h0100) seen_0100 = 1'b1;
                if (prev == 16'h0999 && time_bcd == 16'h1000) seen_1000 = 1'b1;
                prev = time_bcd;
            end
        end
        chk("carry_0099", 16'(seen_0100), 16'd1);
        chk("carry_0999", 16'(seen_1000), 16'd1);
        chk("tout_flag",  16'(timeout),   16'd1);
        chk("tout_time",  time_bcd,       16'h9999);
        chk("tout_best",  best_bcd,       16'h0000);
        chk("tout_stim",  16'(stimulated), 16'd0);
        repeat (5) tick();
        chk("tout_sat", time_bcd, 16'h9999);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_time", time_bcd,         16'h0000);
        chk("restart_stim", 16'(stimulated), 16'd1);

        // start ignored in TIMING, then reset mid-round
        tick();
        chk("mid_led", 16'(led), 16'd1);
        repeat (7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ign_led",  16'(led),   16'd1);
        chk("start_ign_time", time_bcd,   16'h0002);
        chk("start_ign_vld",  16'(valid), 16'd0);
        rst = 1'b1;
        tick();
        chk("mrst_stim", 16'(stimulated),  16'd0);
        chk("mrst_led",  16'(led),         16'd0);
        chk("mrst_time", time_bcd,         16'h0000);
        chk("mrst_best", best_bcd,         16'h9999);
        chk("mrst_tout", 16'(timeout),     16'd0);
        chk("mrst_foul", 16'(false_start), 16'd0);
        rst = 1'b0;
        randomtick = 1'b0;
        tick();
        chk("mrst_idle", 16'(stimulated), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Downstream consumer of the random-delay stimulus tick in the lab4 reaction-time game. It arms the tick generator, lights the stimulus LED when `randomtick` rises, and measures the player's response in milliseconds as 4-digit BCD. It also detects false starts and timeouts, and keeps a best-time register for the seven-segment display stage.

## Interface
- `TICK_DIV`, default 50000: clock cycles per 1 ms tick (50 MHz board clock); must be ≥ 2.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; arms a new round.
- `btn` in 1: debounced, synchronised player button (level).
- `randomtick` in 1: level from the stimulus-delay generator; high once the random delay has expired.
- `stimulated` out 1: drives the generator's `stimulated` input; high in WAIT and TIMING.
- `led` out 1: stimulus light; high only in TIMING.
- `time_bcd` out 16: last result, four BCD digits [15:12]=thousands … [3:0]=ones, in ms.
- `best_bcd` out 16: best valid result since reset, BCD.
- `valid` out 1: high in DONE (`time_bcd` holds a real measurement).
- `false_start` out 1: high in FOUL.
- `timeout` out 1: high in TOUT.

## Operation
- States: IDLE, WAIT, TIMING, DONE, FOUL, TOUT.
- `press` = `btn & ~btn_q`, where `btn_q` is `btn` registered once. Only rising edges count.
- IDLE: `start` → WAIT; `time_bcd` cleared to 0.
- WAIT: `stimulated`=1.
  - `press` → FOUL.
  - Otherwise, `randomtick`=1 → TIMING.
  - If `press` and `randomtick` occur in the same cycle, FOUL wins.
- TIMING: `led`=1, `stimulated`=1.
  - Prescaler counts 0..TICK_DIV-1; each wrap increments `time_bcd` by 1 (BCD carry).
  - `press` → DONE. If `time_bcd` < `best_bcd` (unsigned 16-bit compare; valid for BCD), `best_bcd` ← `time_bcd` on the same edge.
  - When `time_bcd` reaches 16'h9999 → TOUT; `best_bcd` is not updated.
- DONE / FOUL / TOUT: hold outputs; `start` → WAIT; `time_bcd` cleared on entry to WAIT.
- `start` is ignored in WAIT and TIMING.
- Leaving TIMING drops `stimulated`, which resets the generator's counter.
- BCD increment: a digit 9 becomes 0 with carry; saturates at 9999 (never wraps to 0000).
- Reset values:
  - state IDLE.
  - `stimulated`, `led`, `valid`, `false_start`, `timeout` = 0.
  - `time_bcd` = 16'h0000; `best_bcd` = 16'h9999.
  - prescaler = 0; `btn_q` = 0.
- `rst` mid-round: everything returns to reset values on that edge, including `best_bcd`.

## Timing
- All outputs are registered or decoded from the state register; no combinational input→output paths.
- `stimulated` rises 1 cycle after the `start` edge.
- `led` rises 1 cycle after the edge where `randomtick`=1 is sampled in WAIT.
- Prescaler is zeroed on entry to TIMING. The first ms increment is TICK_DIV cycles after entry, so the result truncates (floor) to whole ms.
- `press` detection adds 1 cycle (`btn_q`). `valid` / `false_start` rise on the edge after the cycle in which `press` is true.
- `best_bcd` is updated on the same edge that `valid` rises.

## Structure
- Package `reaction_pkg`:
  - state enum `rt_state_t`.
  - `BCD_MAX` = 16'h9999.
  - `BCD_ZERO` = 16'h0000.
- Sub-module `bcd_counter4`: synchronous clear, increment enable, saturating 4-digit BCD, `at_max` flag.
- Top holds the FSM, prescaler, edge detector and best register.

## Test plan
- Reset, then `start`, `randomtick` after 10 cycles, press after 3×TICK_DIV+1 cycles in TIMING (TICK_DIV=4) → `time_bcd`=16'h0003, `valid`=1, `best_bcd`=16'h0003.
- Second round with a 5 ms response → `time_bcd`=0005, `best_bcd` stays 0003. Third round with 1 ms → `best_bcd`=0001.
- Press in WAIT before `randomtick` → `false_start`=1, `led` never rises, `stimulated` drops next cycle, `best_bcd` unchanged.
- `press` and `randomtick` in the same cycle → FOUL.
- `btn` held high across entry to TIMING → no result until a release and a new rising edge.
- No press in TIMING → `time_bcd` passes 0099→0100 and 0999→1000 correctly, saturates at 9999, `timeout`=1, `best_bcd` unchanged. Then `start` → WAIT with `time_bcd`=0000.
- `rst` asserted mid-TIMING → all outputs at reset values next edge, `best_bcd`=9999. `start` pulsed during TIMING → no effect.
